del_engine_fsm: RTL and testbench
=================================

Name: del_engine_fsm

Overview:
Parametrised successor to the controller's single-key delete sub-FSM. It runs a key delete with a configurable memory lookup latency, and a new flush-all mode that walks the occupancy vector and deletes every valid cell. It sits under the parent command FSM and drives the memory block's lookup/delete command lines. It has an explicit start/busy/done/error handshake, abort, error codes and a deleted-entry counter.

Parameters:
NUM_ENTRIES, 16, number of memory cells; width of one-hot index buses (>=2).
LOOKUP_LAT, 1, cycles from lookup_out to valid hit/idx_in (>=1).
CNT_W, $clog2(NUM_ENTRIES+1), width of del_count.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  single-cycle request; sampled only in IDLE.
mode  in  1  0 = delete by key, 1 = flush all; sampled with start.
abort  in  1  cancel the operation in progress.
hit  in  1  memory key-match flag.
idx_in  in  NUM_ENTRIES  one-hot index of the matched cell.
valid_in  in  NUM_ENTRIES  cell occupancy vector from memory.
lookup_out  out  1  request key lookup in memory.
delete_out  out  1  delete the cell addressed by idx_out.
idx_out  out  NUM_ENTRIES  one-hot target cell; 0 when delete_out=0.
busy  out  1  high in every state except IDLE.
cmd  out  sub_cmd_t  .done / .error, each a one-cycle pulse.
err_code  out  del_err_e  reason for the error; held until the next start.
del_count  out  CNT_W  cells deleted by the last or current operation.

Behaviour:
- Reset (async, any state): state=IDLE; counters, saved index, del_count and err_code (ERR_NONE) cleared. All outputs 0.
- IDLE: no command outputs. On start:
  - mode=0 -> LOOKUP, lat_cnt=LOOKUP_LAT-1.
  - mode=1 -> FLUSH, ptr=0.
  - Either way: del_count=0, err_code=ERR_NONE.
- LOOKUP: lookup_out=1 every cycle. Decrement lat_cnt. When lat_cnt==0, sample hit and idx_in:
  - hit=1 and idx_in one-hot -> save idx, go DELETE.
  - hit=0 -> ERROR with ERR_NOT_FOUND.
  - hit=1 and idx_in not one-hot (0 or multiple bits) -> ERROR with ERR_MULTI_HIT.
- DELETE: exactly one cycle with delete_out=1 and idx_out=saved idx; del_count=1. Then DONE.
- FLUSH: one cell per cycle.
  - If valid_in[ptr]: delete_out=1, idx_out=onehot(ptr), del_count++.
  - ptr increments each cycle. When ptr==NUM_ENTRIES-1 the current cell is processed, then go DONE (no wrap).
  - A flush takes exactly NUM_ENTRIES cycles regardless of occupancy.
- DONE: cmd.done=1 for one cycle -> IDLE.
- ERROR: cmd.error=1 for one cycle -> IDLE.
- Latency:
  - Key delete, start to done pulse: LOOKUP_LAT+2 cycles.
  - Flush, start to done pulse: NUM_ENTRIES+1 cycles.
- abort in LOOKUP/DELETE/FLUSH:
  - Same cycle: delete_out and lookup_out forced to 0.
  - Next state ERROR with ERR_ABORTED; del_count keeps the deletes already issued.
  - abort in IDLE/DONE/ERROR is ignored.
- start while busy is ignored, with no queueing.
- start and abort asserted together in IDLE: start wins, abort ignored.
- cmd.done and cmd.error are never high together. lookup_out and delete_out are never high together.

Decomposition:
- Add to ctrl_types_pkg:
  - del_eng_state_e {IDLE, LOOKUP, DELETE, FLUSH, DONE, ERROR}.
  - del_err_e {ERR_NONE, ERR_NOT_FOUND, ERR_MULTI_HIT, ERR_ABORTED}, 2 bits.
  - Reuse sub_cmd_t.
- One sub-module, onehot_check (combinational: is_onehot flag plus binary-to-one-hot helper). Everything else stays in del_engine_fsm.

Test Plan:
- Key hit: LOOKUP_LAT=3, start mode=0, hit=1, idx_in=0x0010 on cycle 3 -> lookup_out high 3 cycles, one cycle delete_out=1 with idx_out=0x0010, done pulse at cycle 5, del_count=1.
- Key miss: hit=0 -> no delete_out, error pulse, err_code=ERR_NOT_FOUND, busy drops the next cycle.
- Multi-hit: hit=1, idx_in=0x0006 -> error pulse, err_code=ERR_MULTI_HIT, delete_out never asserted.
- Flush: NUM_ENTRIES=16, valid_in=0x8421 -> delete_out on cells 0, 5, 10, 15 with matching one-hot idx_out, done at cycle 17, del_count=4. With valid_in=0 -> done at cycle 17, del_count=0.
- Abort during flush at ptr=6 with valid_in=0xFFFF -> 6 deletes issued, none in the abort cycle, error with ERR_ABORTED, del_count=6.
- Async rst asserted mid-LOOKUP, and start pulsed while busy -> immediate IDLE with all outputs 0; ignored start causes no state change.

Source files
------------

// File: rtl/ctrl_types_pkg.sv
// rtl/ctrl_types_pkg.sv - shared controller types: sub-FSM command pulses, delete engine state and error codes
package ctrl_types_pkg;

  typedef struct packed {
    logic done;
    logic error;
  } sub_cmd_t;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    DELETE,
    FLUSH,
    DONE,
    ERROR
  } del_eng_state_e;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_NOT_FOUND,
    ERR_MULTI_HIT,
    ERR_ABORTED
  } del_err_e;

endpackage

// File: rtl/onehot_check.sv
// rtl/onehot_check.sv - one-hot validity flag and binary-to-one-hot decode
module onehot_check #(
  parameter int N     = 16,
  parameter int BIN_W = $clog2(N)
) (
  input  logic [N-1:0]     i_vec,
  output logic             o_is_onehot,
  input  logic [BIN_W-1:0] i_bin,
  output logic [N-1:0]     o_onehot
);

  // Clearing the lowest set bit leaves zero only when exactly one bit was set.
  assign o_is_onehot = (i_vec != '0) && ((i_vec & (i_vec - N'(1))) == '0);
  assign o_onehot    = N'(1) << i_bin;

endmodule

// File: rtl/del_engine_fsm.sv
// rtl/del_engine_fsm.sv - key delete / flush-all sub-FSM driving the memory lookup and delete lines
module del_engine_fsm
  import ctrl_types_pkg::*;
#(
  parameter int NUM_ENTRIES = 16,
  parameter int LOOKUP_LAT  = 1,
  parameter int CNT_W       = $clog2(NUM_ENTRIES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   mode,
  input  logic                   abort,
  input  logic                   hit,
  input  logic [NUM_ENTRIES-1:0] idx_in,
  input  logic [NUM_ENTRIES-1:0] valid_in,
  output logic                   lookup_out,
  output logic                   delete_out,
  output logic [NUM_ENTRIES-1:0] idx_out,
  output logic                   busy,
  output sub_cmd_t               cmd,
  output del_err_e               err_code,
  output logic [CNT_W-1:0]       del_count
);

  localparam int PTR_W = $clog2(NUM_ENTRIES);
  localparam int LAT_W = (LOOKUP_LAT > 1) ? $clog2(LOOKUP_LAT) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_ENTRIES - 1);

  del_eng_state_e           r_state;
  del_eng_state_e           w_next;
  logic [LAT_W-1:0]         r_lat_cnt;
  logic [PTR_W-1:0]         r_ptr;
  logic [NUM_ENTRIES-1:0]   r_idx;
  logic [CNT_W-1:0]         r_del_count;
  del_err_e                 r_err;
  logic                     w_idx_onehot;
  logic [NUM_ENTRIES-1:0]   w_ptr_onehot;
  logic                     w_lat_done;
  logic                     w_flush_del;

  onehot_check #(
    .N     (NUM_ENTRIES),
    .BIN_W (PTR_W)
  ) u_onehot_check (
    .i_vec       (idx_in),
    .o_is_onehot (w_idx_onehot),
    .i_bin       (r_ptr),
    .o_onehot    (w_ptr_onehot)
  );

  assign w_lat_done  = (r_lat_cnt == '0);
  assign w_flush_del = valid_in[r_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = mode ? FLUSH : LOOKUP;
        end
      end
      LOOKUP: begin
        if (abort) begin
          w_next = ERROR;
        end else if (w_lat_done) begin
          w_next = (hit && w_idx_onehot) ? DELETE : ERROR;
        end
      end
      DELETE: w_next = abort ? ERROR : DONE;
      FLUSH: begin
        if (abort) begin
          w_next = ERROR;
        end else if (r_ptr == LAST_PTR) begin
          w_next = DONE;
        end
      end
      DONE:    w_next = IDLE;
      ERROR:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Abort suppresses the memory command lines in the very cycle it is seen.
  always_comb begin
    lookup_out = 1'b0;
    delete_out = 1'b0;
    idx_out    = '0;
    busy       = (r_state != IDLE);
    cmd        = '0;
    case (r_state)
      LOOKUP: lookup_out = !abort;
      DELETE: begin
        delete_out = !abort;
        idx_out    = abort ? '0 : r_idx;
      end
      FLUSH: begin
        delete_out = !abort && w_flush_del;
        idx_out    = (!abort && w_flush_del) ? w_ptr_onehot : '0;
      end
      DONE:    cmd.done  = 1'b1;
      ERROR:   cmd.error = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lat_cnt   <= '0;
      r_ptr       <= '0;
      r_idx       <= '0;
      r_del_count <= '0;
      r_err       <= ERR_NONE;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_lat_cnt   <= LAT_W'(LOOKUP_LAT - 1);
            r_ptr       <= '0;
            r_del_count <= '0;
            r_err       <= ERR_NONE;
          end
        end
        LOOKUP: begin
          if (abort) begin
            r_err <= ERR_ABORTED;
          end else if (w_lat_done) begin
            if (!hit) begin
              r_err <= ERR_NOT_FOUND;
            end else if (!w_idx_onehot) begin
              r_err <= ERR_MULTI_HIT;
            end else begin
              r_idx <= idx_in;
            end
          end else begin
            r_lat_cnt <= r_lat_cnt - LAT_W'(1);
          end
        end
        DELETE: begin
          if (abort) begin
            r_err <= ERR_ABORTED;
          end else begin
            r_del_count <= CNT_W'(1);
          end
        end
        FLUSH: begin
          if (abort) begin
            r_err <= ERR_ABORTED;
          end else begin
            if (w_flush_del) begin
              r_del_count <= r_del_count + CNT_W'(1);
            end
            if (r_ptr != LAST_PTR) begin
              r_ptr <= r_ptr + PTR_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign err_code  = r_err;
  assign del_count = r_del_count;

endmodule

// File: tb/tb_del_engine_fsm.sv
// tb/tb_del_engine_fsm.sv - randomized and directed bench for del_engine_fsm against a trace model
module tb_del_engine_fsm;
  import ctrl_types_pkg::*;

  localparam int N   = 16;
  localparam int LAT = 3;
  localparam int CW  = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start, mode, abort, hit;
  logic [N-1:0]  idx_in, valid_in;
  logic          lookup_out, delete_out, busy;
  logic [N-1:0]  idx_out;
  sub_cmd_t      cmd;
  del_err_e      err_code;
  logic [CW-1:0] del_count;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;
  int op_no   = 0;

  always #5 clk = ~clk;

  del_engine_fsm #(
    .NUM_ENTRIES (N),
    .LOOKUP_LAT  (LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .abort      (abort),
    .hit        (hit),
    .idx_in     (idx_in),
    .valid_in   (valid_in),
    .lookup_out (lookup_out),
    .delete_out (delete_out),
    .idx_out    (idx_out),
    .busy       (busy),
    .cmd        (cmd),
    .err_code   (err_code),
    .del_count  (del_count)
  );

  function automatic logic [20:0] mk(input logic b, input logic lk, input logic dl,
                                     input logic [N-1:0] ix, input logic dn, input logic er);
    return {b, lk, dl, ix, dn, er};
  endfunction

  function automatic logic [20:0] obs_vec();
    return {busy, lookup_out, delete_out, idx_out, cmd.done, cmd.error};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Builds the expected per-cycle trace from the operation rules, then drives and compares.
  task automatic run_op(input bit m, input bit h, input logic [N-1:0] idx, input logic [N-1:0] vld,
                        input int ab, input bit junk);
    logic [20:0] q[$];
    int          cnt;
    logic [1:0]  ecode;
    bit          stop;
    q     = {};
    cnt   = 0;
    ecode = 2'd0;
    stop  = 1'b0;
    op_no++;
    q.push_back(mk(0, 0, 0, '0, 0, 0));
    if (!m) begin
      for (int c = 1; c <= LAT && !stop; c++) begin
        if (ab == c) begin
          q.push_back(mk(1, 0, 0, '0, 0, 0));
          ecode = 2'd3;
          stop  = 1'b1;
        end else begin
          q.push_back(mk(1, 1, 0, '0, 0, 0));
        end
      end
      if (!stop) begin
        if (!h) begin
          ecode = 2'd1;
          stop  = 1'b1;
        end else if ($countones(idx) != 1) begin
          ecode = 2'd2;
          stop  = 1'b1;
        end else if (ab == LAT + 1) begin
          q.push_back(mk(1, 0, 0, '0, 0, 0));
          ecode = 2'd3;
          stop  = 1'b1;
        end else begin
          q.push_back(mk(1, 0, 1, idx, 0, 0));
          cnt = 1;
        end
      end
    end else begin
      for (int p = 0; p < N && !stop; p++) begin
        if (ab == p + 1) begin
          q.push_back(mk(1, 0, 0, '0, 0, 0));
          ecode = 2'd3;
          stop  = 1'b1;
        end else begin
          q.push_back(mk(1, 0, vld[p], vld[p] ? (N'(1) << p) : '0, 0, 0));
          cnt += int'(vld[p]);
        end
      end
    end
    q.push_back(stop ? mk(1, 0, 0, '0, 0, 1) : mk(1, 0, 0, '0, 1, 0));
    q.push_back(mk(0, 0, 0, '0, 0, 0));

    for (int t = 0; t < q.size(); t++) begin
      start    = (t == 0) || (junk && t < q.size() - 1 && $urandom_range(0, 2) == 0);
      mode     = (t == 0) ? m : 1'($urandom_range(0, 1));
      abort    = (t == ab);
      hit      = (t == LAT) ? h : 1'($urandom_range(0, 1));
      idx_in   = (t == LAT) ? idx : N'($urandom);
      valid_in = vld;
      #4;
      chk($sformatf("op%0d_cycle%0d", op_no, t), 32'(obs_vec()), 32'(q[t]));
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    abort = 1'b0;
    chk($sformatf("op%0d_err_code", op_no), 32'(err_code), 32'(ecode));
    chk($sformatf("op%0d_del_count", op_no), 32'(del_count), 32'(cnt));
  endtask

  task automatic reset_mid(input bit m, input int exp_cnt);
    op_no++;
    start    = 1'b1;
    mode     = m;
    abort    = 1'b0;
    valid_in = '1;
    hit      = 1'b0;
    idx_in   = '0;
    for (int t = 0; t < 3; t++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    chk($sformatf("op%0d_busy_before_rst", op_no), 32'(busy), 32'd1);
    chk($sformatf("op%0d_count_before_rst", op_no), 32'(del_count), 32'(exp_cnt));
    #2;
    rst = 1'b1;
    #1;
    chk($sformatf("op%0d_outs_in_rst", op_no), 32'(obs_vec()), 32'd0);
    chk($sformatf("op%0d_count_in_rst", op_no), 32'(del_count), 32'd0);
    chk($sformatf("op%0d_err_in_rst", op_no), 32'(err_code), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    #4;
    chk($sformatf("op%0d_idle_after_rst", op_no), 32'(obs_vec()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    mode     = 1'b0;
    abort    = 1'b0;
    hit      = 1'b0;
    idx_in   = '0;
    valid_in = '0;
    #12;
    chk("reset_outputs", 32'(obs_vec()), 32'd0);
    chk("reset_err_code", 32'(err_code), 32'd0);
    chk("reset_del_count", 32'(del_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op(0, 1, 16'h0010, 16'h0000, -1, 0);
    run_op(0, 0, 16'h0010, 16'h0000, -1, 0);
    run_op(0, 1, 16'h0006, 16'h0000, -1, 0);
    run_op(0, 1, 16'h0000, 16'h0000, -1, 0);
    run_op(1, 0, 16'h0000, 16'h8421, -1, 0);
    run_op(1, 0, 16'h0000, 16'h0000, -1, 0);
    run_op(1, 0, 16'h0000, 16'hFFFF, 7, 0);
    run_op(0, 1, 16'h0100, 16'h0000, LAT + 1, 0);
    run_op(0, 1, 16'h0001, 16'h0000, 2, 0);
    run_op(1, 0, 16'h0000, 16'hFFFF, 0, 1);
    run_op(0, 1, 16'h8000, 16'h0000, LAT + 2, 1);
    run_op(1, 0, 16'h0000, 16'hA5A5, 16, 1);

    reset_mid(1, 2);
    reset_mid(0, 0);

    for (int k = 0; k < 30; k++) begin
      bit           m, h;
      logic [N-1:0] ix, vl;
      int           ab;
      m  = 1'($urandom_range(0, 1));
      h  = ($urandom_range(0, 4) != 0);
      ix = ($urandom_range(0, 2) != 0) ? (N'(1) << $urandom_range(0, N - 1)) : N'($urandom);
      vl = N'($urandom);
      ab = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, m ? N + 3 : LAT + 4));
      run_op(m, h, ix, vl, ab, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
